// File: rtl/systemne_nios2_qsys_0_dct_ctrl_if.sv
// Fragment-capture and frame-output handshake bundle for the Nios II OCI DCT buffer controller.
interface systemne_nios2_qsys_0_dct_ctrl_if #(
    parameter int FRAG_W = 2,
    parameter int BUF_W  = 30,
    parameter int CNT_W  = 4
);
    logic              enable;
    logic              frag_valid;
    logic [FRAG_W-1:0] frag_data;
    logic              frag_ready;
    logic              flush_req;
    logic              test_ending;
    logic [BUF_W-1:0]  dct_buffer;
    logic [CNT_W-1:0]  dct_count;
    logic              out_valid;
    logic              out_ready;
    logic [BUF_W-1:0]  out_data;
    logic [CNT_W-1:0]  out_count;
    logic              test_has_ended;

    modport master (
        output enable, frag_valid, frag_data, flush_req, test_ending, out_ready,
        input  frag_ready, dct_buffer, dct_count, out_valid, out_data, out_count,
               test_has_ended
    );

    modport slave (
        input  enable, frag_valid, frag_data, flush_req, test_ending, out_ready,
        output frag_ready, dct_buffer, dct_count, out_valid, out_data, out_count,
               test_has_ended
    );
endinterface

// File: rtl/systemne_nios2_qsys_0_dct_ctrl.sv
// Nios II OCI DCT buffer sequencer: packs trace fragments into frames, drains them
// over valid/ready, and closes out capture at end of test.
//
//  state | meaning
//  FILL  | accepting fragments into the shift buffer
//  DRAIN | frame presented on out_*, waiting for out_ready
//  DONE  | final frame drained, capture stopped until reset
module systemne_nios2_qsys_0_dct_ctrl #(
    parameter int FRAG_W = 2,
    parameter int BUF_W  = 30,
    parameter int CNT_W  = 4
) (
    input  logic clk,
    input  logic reset_n,
    systemne_nios2_qsys_0_dct_ctrl_if.slave bus
);
    localparam int MAX_FRAGS = BUF_W / FRAG_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_FRAGS - 1);

    typedef enum logic [1:0] {FILL, DRAIN, DONE} state_t;

    state_t            state;
    logic [BUF_W-1:0]  buf_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              out_valid_q;
    logic [BUF_W-1:0]  out_data_q;
    logic [CNT_W-1:0]  out_count_q;
    logic              ended_q;
    logic              ending_pend;

    logic              accept;
    logic              ending;
    logic              close_frame;
    logic [BUF_W-1:0]  eff_buf;
    logic [CNT_W-1:0]  eff_cnt;

    assign bus.frag_ready     = (state == FILL) & bus.enable;
    assign bus.dct_buffer     = buf_q;
    assign bus.dct_count      = cnt_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_data       = out_data_q;
    assign bus.out_count      = out_count_q;
    assign bus.test_has_ended = ended_q;

    // A fragment accepted in the closing cycle belongs to the frame being closed.
    always_comb begin
        accept      = bus.frag_ready & bus.frag_valid;
        ending      = bus.test_ending | ending_pend;
        eff_buf     = buf_q;
        eff_cnt     = cnt_q;
        if (accept) begin
            eff_buf = {buf_q[BUF_W-FRAG_W-1:0], bus.frag_data};
            eff_cnt = cnt_q + CNT_W'(1);
        end
        close_frame = (accept && (cnt_q == LAST_CNT)) ||
                      ((bus.flush_req || ending) && (eff_cnt != '0));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= FILL;
            buf_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            ended_q     <= 1'b0;
            ending_pend <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (bus.test_ending) ending_pend <= 1'b1;
                    if (close_frame) begin
                        out_data_q  <= eff_buf;
                        out_count_q <= eff_cnt;
                        out_valid_q <= 1'b1;
                        buf_q       <= '0;
                        cnt_q       <= '0;
                        state       <= DRAIN;
                    end else if (ending) begin
                        ended_q <= 1'b1;
                        state   <= DONE;
                    end else if (accept) begin
                        buf_q <= eff_buf;
                        cnt_q <= eff_cnt;
                    end
                end
                DRAIN: begin
                    if (bus.test_ending) ending_pend <= 1'b1;
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (ending) begin
                            ended_q <= 1'b1;
                            state   <= DONE;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule
